// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_pkg
//  Brief    : Shared PS/2 types, timing defaults and keyboard command codes.
//  Revision : 1.0  initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RTS       = 3'd1,
        ST_START     = 3'd2,
        ST_DATA      = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } ps2_tx_state_e;

    localparam int DEF_INHIBIT_CYCLES = 12000;
    localparam int DEF_TIMEOUT_CYCLES = 1_500_000;
    localparam int FILTER_LEN         = 8;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] ACK_BYTE    = 8'hFA;

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_line_filter
//  Brief    : 2-FF synchronizer, 8-sample glitch filter and falling-edge tick.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_line_filter
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_line,
    output logic o_level,
    output logic o_fall_tick
);

    logic [1:0]            r_sync;
    logic [FILTER_LEN-1:0] r_hist;
    logic                  r_level;
    logic                  r_fall;

    // Reset to the idle (pulled-up) level so no edge is reported after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '1;
            r_hist  <= '1;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_line};
            r_hist <= {r_hist[FILTER_LEN-2:0], r_sync[1]};
            r_fall <= 1'b0;
            if (&r_hist) begin
                r_level <= 1'b1;
            end else if (~|r_hist) begin
                r_level <= 1'b0;
                r_fall  <= r_level;
            end
        end
    end

    assign o_level     = r_level;
    assign o_fall_tick = r_fall;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_host_tx
//  Brief    : Host-to-device PS/2 command transmitter with ack check/timeout.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] C_INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_e    r_state, w_next_state;
    logic [CNT_W-1:0] r_cnt,   w_cnt_next;
    logic [8:0]       r_shift, w_shift_next;
    logic [3:0]       r_n,     w_n_next;
    logic             r_err,   w_err_next;
    logic             r_done,  w_done_next;
    logic             w_drive_c, w_drive_d;

    logic w_c_level, w_c_fall;
    logic w_d_level, w_unused_d_fall;
    logic w_timeout;

    ps2_line_filter u_filt_c (
        .clk         (clk),
        .rst         (Reset),
        .i_line      (ps2c),
        .o_level     (w_c_level),
        .o_fall_tick (w_c_fall)
    );

    ps2_line_filter u_filt_d (
        .clk         (clk),
        .rst         (Reset),
        .i_line      (ps2d),
        .o_level     (w_d_level),
        .o_fall_tick (w_unused_d_fall)
    );

    assign w_timeout = (r_cnt == C_TO_LAST);

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_n     <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            r_shift <= w_shift_next;
            r_n     <= w_n_next;
            r_err   <= w_err_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = '0;
        w_shift_next = r_shift;
        w_n_next     = r_n;
        w_err_next   = r_err;
        w_done_next  = 1'b0;
        w_drive_c    = 1'b0;
        w_drive_d    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (wr_ps2) begin
                    w_shift_next = {odd_parity(din), din};
                    w_err_next   = 1'b0;
                    w_next_state = ST_RTS;
                end
            end

            // Request-to-send: hold clock low, pull data low in the final cycle.
            ST_RTS: begin
                w_drive_c  = 1'b1;
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt == C_INH_LAST) begin
                    w_drive_d    = 1'b1;
                    w_cnt_next   = '0;
                    w_next_state = ST_START;
                end
            end

            ST_START: begin
                w_drive_d  = 1'b1;
                w_cnt_next = r_cnt + 1'b1;
                if (w_c_fall) begin
                    w_cnt_next   = '0;
                    w_n_next     = 4'd8;
                    w_next_state = ST_DATA;
                end else if (w_timeout) begin
                    w_cnt_next   = '0;
                    w_err_next   = 1'b1;
                    w_done_next  = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end

            ST_DATA: begin
                w_drive_d  = ~r_shift[0];
                w_cnt_next = r_cnt + 1'b1;
                if (w_c_fall) begin
                    w_cnt_next = '0;
                    if (r_n == 4'd0) begin
                        w_next_state = ST_STOP;
                    end else begin
                        w_shift_next = {1'b1, r_shift[8:1]};
                        w_n_next     = r_n - 4'd1;
                    end
                end else if (w_timeout) begin
                    w_cnt_next   = '0;
                    w_err_next   = 1'b1;
                    w_done_next  = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end

            // Data released; the device pulls it low on the 11th edge to ack.
            ST_STOP: begin
                w_cnt_next = r_cnt + 1'b1;
                if (w_c_fall) begin
                    w_cnt_next   = '0;
                    w_err_next   = w_d_level;
                    w_next_state = ST_WAIT_IDLE;
                end else if (w_timeout) begin
                    w_cnt_next   = '0;
                    w_err_next   = 1'b1;
                    w_done_next  = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end

            ST_WAIT_IDLE: begin
                if (w_c_level && w_d_level) begin
                    w_done_next  = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign ps2c = w_drive_c ? 1'b0 : 1'bz;
    assign ps2d = w_drive_d ? 1'b0 : 1'bz;

    assign tx_idle      = (r_state == ST_IDLE);
    assign tx_done_tick = r_done;
    assign tx_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_host_tx
//  Brief    : Self-checking bench with a PS/2 device model for ps2_host_tx.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int INH  = 200;
    localparam int TO   = 600;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       Reset;
    logic       wr_ps2;
    logic [7:0] din;
    wire        ps2c;
    wire        ps2d;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_err;
    logic       bfm_c_low = 1'b0;
    logic       bfm_d_low = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = bfm_c_low ? 1'b0 : 1'bz;
    assign ps2d = bfm_d_low ? 1'b0 : 1'bz;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .Reset        (Reset),
        .wr_ps2       (wr_ps2),
        .din          (din),
        .ps2c         (ps2c),
        .ps2d         (ps2d),
        .tx_idle      (tx_idle),
        .tx_done_tick (tx_done_tick),
        .tx_err       (tx_err)
    );

    typedef struct {
        logic [7:0] din;
        bit         ack;
        logic [9:0] exp_bits;
        bit         exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bits seen by the device on rising edges 1..10: d0..d7, odd parity, stop.
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b};
    endfunction

    task automatic send_cmd(input logic [7:0] b);
        @(negedge clk);
        wr_ps2 = 1'b1;
        din    = b;
        @(negedge clk);
        wr_ps2 = 1'b0;
        din    = 8'($urandom);
        chk("accept_tx_idle", tx_idle, 1'b0);
        chk("accept_clk_low", ps2c, 1'b0);
        chk("accept_err_clr", tx_err, 1'b0);
    endtask

    task automatic device_frame(input bit ack, input int rst_edge,
                                output logic [9:0] bits, output logic start_bit,
                                output int low_cnt, output int dlow_cnt, output bit aborted);
        bits = '0; start_bit = 1'b1; low_cnt = 0; dlow_cnt = 0; aborted = 1'b0;
        while (ps2c === 1'b0 && low_cnt < 4 * INH) begin
            low_cnt++;
            if (ps2d === 1'b0) dlow_cnt++;
            @(negedge clk);
        end
        start_bit = ps2d;
        repeat (20) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            for (int i = 0; i < HALF; i++) begin
                @(negedge clk);
                if (k == 11 && ack && i == HALF / 4) bfm_d_low = 1'b1;
            end
            bfm_c_low = 1'b1;
            if (k == rst_edge) begin
                repeat (15) @(negedge clk);
                Reset = 1'b1;
                @(negedge clk);
                Reset = 1'b0;
                chk("rst_mid_data_released", ps2d, 1'b1);
                chk("rst_mid_tx_idle", tx_idle, 1'b1);
                bfm_c_low = 1'b0;
                aborted   = 1'b1;
                return;
            end
            repeat (HALF) @(negedge clk);
            bfm_c_low = 1'b0;
            if (k <= 10) bits[k-1] = ps2d;
        end
        bfm_d_low = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input bit exp_err, input int limit);
        bit found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            if (tx_done_tick) found = 1'b1;
        end
        chk({tag, "_done_seen"}, found, 1'b1);
        if (found) begin
            chk({tag, "_err"}, tx_err, exp_err);
            chk({tag, "_idle_at_done"}, tx_idle, 1'b1);
            chk({tag, "_clk_released"}, ps2c, 1'b1);
            chk({tag, "_data_released"}, ps2d, 1'b1);
            @(negedge clk);
            chk({tag, "_done_one_cycle"}, tx_done_tick, 1'b0);
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b, input bit ack,
                             input logic [9:0] exp_bits, input bit exp_err);
        logic [9:0] bits;
        logic       sb;
        int         lc, dl;
        bit         ab;
        send_cmd(b);
        device_frame(ack, 0, bits, sb, lc, dl, ab);
        chk({tag, "_inhibit_len"}, lc, INH);
        chk({tag, "_rts_data_low"}, dl, 1);
        chk({tag, "_start_bit"}, sb, 1'b0);
        chk({tag, "_bits"}, bits, exp_bits);
        finish_frame(tag, exp_err, 200);
        repeat (30) @(negedge clk);
    endtask

    initial begin
        logic [9:0] bits;
        logic       sb;
        int         lc, dl, cnt, t;
        bit         ab, found;
        logic [7:0] b;
        bit         ack;

        vecs[0] = '{din: 8'hED, ack: 1'b1, exp_bits: 10'h3ED, exp_err: 1'b0};
        vecs[1] = '{din: 8'h01, ack: 1'b1, exp_bits: 10'h201, exp_err: 1'b0};
        vecs[2] = '{din: 8'hFF, ack: 1'b1, exp_bits: 10'h3FF, exp_err: 1'b0};
        vecs[3] = '{din: 8'hF4, ack: 1'b0, exp_bits: 10'h2F4, exp_err: 1'b1};
        vecs[4] = '{din: 8'hFA, ack: 1'b1, exp_bits: 10'h3FA, exp_err: 1'b0};

        Reset = 1'b1; wr_ps2 = 1'b0; din = 8'h00;
        repeat (5) @(negedge clk);
        chk("reset_tx_idle", tx_idle, 1'b1);
        chk("reset_done", tx_done_tick, 1'b0);
        chk("reset_err", tx_err, 1'b0);
        Reset = 1'b0;
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_done_tick) cnt++;
        end
        chk("idle_done_pulses", cnt, 0);
        chk("idle_clk_high", ps2c, 1'b1);
        chk("idle_data_high", ps2d, 1'b1);
        chk("idle_tx_idle", tx_idle, 1'b1);

        for (int v = 0; v < 5; v++)
            run_frame($sformatf("vec%0d", v), vecs[v].din, vecs[v].ack,
                      vecs[v].exp_bits, vecs[v].exp_err);

        for (int r = 0; r < 6; r++) begin
            b   = 8'($urandom);
            ack = ($urandom_range(0, 3) != 0);
            run_frame($sformatf("rnd%0d", r), b, ack, model_frame(b), !ack);
        end

        // Device never clocks: the host must give up after the timeout.
        send_cmd(8'hF4);
        lc = 0;
        while (ps2c === 1'b0 && lc < 4 * INH) begin
            lc++;
            @(negedge clk);
        end
        chk("to_inhibit_len", lc, INH);
        t = 0; found = 1'b0;
        while (!found && t < 3 * TO) begin
            if (tx_done_tick) found = 1'b1;
            else begin
                @(negedge clk);
                t++;
            end
        end
        chk("to_done_seen", found, 1'b1);
        chk("to_latency_ok", (t >= TO - 1 && t <= TO + 1), 1'b1);
        chk("to_err", tx_err, 1'b1);
        chk("to_clk_released", ps2c, 1'b1);
        chk("to_data_released", ps2d, 1'b1);
        repeat (30) @(negedge clk);

        // Reset during the data phase, at the fifth device clock edge.
        send_cmd(8'hA5);
        device_frame(1'b1, 5, bits, sb, lc, dl, ab);
        chk("rst_aborted", ab, 1'b1);
        chk("rst_low_nibble", bits[3:0], 4'h5);
        cnt = 0;
        repeat (150) begin
            @(negedge clk);
            if (tx_done_tick) cnt++;
        end
        chk("rst_no_done", cnt, 0);
        chk("rst_idle_after", tx_idle, 1'b1);
        chk("rst_clk_high", ps2c, 1'b1);
        chk("rst_err_clear", tx_err, 1'b0);

        // Start requests while busy are ignored; the frame keeps the first byte.
        send_cmd(8'h3C);
        fork
            device_frame(1'b1, 0, bits, sb, lc, dl, ab);
            begin
                repeat (100) @(negedge clk);
                wr_ps2 = 1'b1; din = 8'hC3;
                @(negedge clk);
                wr_ps2 = 1'b0;
                repeat (300) @(negedge clk);
                wr_ps2 = 1'b1; din = 8'h00;
                @(negedge clk);
                wr_ps2 = 1'b0;
            end
        join
        chk("busy_inhibit_len", lc, INH);
        chk("busy_bits", bits, model_frame(8'h3C));
        finish_frame("busy", 1'b0, 200);
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (!tx_idle) cnt++;
        end
        chk("busy_no_restart", cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
